// File: rtl/win3x3_pkg.sv
// Shared window geometry, element indexing and frame-tracking states for the 3x3 window generator.
package win3x3_pkg;

   localparam int WIN_ROWS = 3;
   localparam int WIN_COLS = 3;

   typedef enum logic {WAIT_SOF, ACTIVE} win_state_e;

   // Flat element index of window element (r,c) inside win_data.
   function automatic int idx(input int r, input int c);
      return WIN_COLS * r + c;
   endfunction

endpackage

// File: rtl/win3x3_line_ram.sv
// One line buffer: simple dual-port RAM, one write port and one synchronous read port.
// A read and a write to the same address in the same cycle return the old contents.
module win3x3_line_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 1024,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
      if (re) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/window_3x3_gen.sv
// 3x3 neighbourhood generator: two line buffers + column shift, interior windows only.
// Optional line-length error flag enabled with `define WIN3X3_ERR_EN.
module window_3x3_gen
   import win3x3_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int MAX_LINE_WIDTH = 1024,
   parameter int ADDR_WIDTH     = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_val,
   output logic                    in_rdy,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic                    in_sof,
   input  logic                    in_eof,
   input  logic                    in_sol,
   input  logic                    in_eol,
   output logic                    win_val,
   input  logic                    win_rdy,
   output logic [9*DATA_WIDTH-1:0] win_data,
   output logic                    win_sof,
   output logic                    win_eof,
   output logic                    win_sol,
   output logic                    win_eol
`ifdef WIN3X3_ERR_EN
   ,
   output logic                    err_line_len
`endif
);

   localparam logic [ADDR_WIDTH:0] MAX_X = (ADDR_WIDTH+1)'(MAX_LINE_WIDTH);
   localparam logic [ADDR_WIDTH:0] X_TWO = (ADDR_WIDTH+1)'(2);

   win_state_e                         st;
   logic                               en, accept, take, emit;
   logic [ADDR_WIDTH:0]                x_q, x_nxt;
   logic [1:0]                         y_q, y_nxt;   // saturates at 3: only y==2 / y>=2 matter
   logic                               s1_vld, s1_emit, s1_sof, s1_eof, s1_sol, s1_eol;
   logic [ADDR_WIDTH:0]                s1_x;
   logic [DATA_WIDTH-1:0]              s1_pix, lb0_rd, lb1_rd;
   logic [WIN_ROWS-1:0][DATA_WIDTH-1:0] col_new, sh1, sh2;

   assign en     = ~win_val | win_rdy;
   assign in_rdy = en;
   assign accept = in_val & en;

   // Position of the incoming pixel; pixels in WAIT_SOF without in_sof are dropped.
   always_comb begin
      take  = (st == ACTIVE) | in_sof;
      x_nxt = x_q;
      y_nxt = y_q;
      if (in_sof) begin
         x_nxt = '0;
         y_nxt = '0;
      end else if (in_sol) begin
         x_nxt = '0;
         y_nxt = (y_q == 2'd3) ? 2'd3 : y_q + 2'd1;
      end else if (x_q != MAX_X) begin
         x_nxt = x_q + 1'b1;
      end
   end

   assign emit    = take & (x_nxt >= X_TWO) & (y_nxt >= 2'd2) & (x_nxt < MAX_X);
   assign col_new = {lb1_rd, lb0_rd, s1_pix};

   // Writes trail reads by one stage so lb1 can take the old lb0 word.
   win3x3_line_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MAX_LINE_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_lb0 (
      .clk     (clk),
      .we      (en & s1_vld & (s1_x < MAX_X)),
      .wr_addr (s1_x[ADDR_WIDTH-1:0]),
      .wr_data (s1_pix),
      .re      (accept & take & (x_nxt < MAX_X)),
      .rd_addr (x_nxt[ADDR_WIDTH-1:0]),
      .rd_data (lb0_rd)
   );

   win3x3_line_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MAX_LINE_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_lb1 (
      .clk     (clk),
      .we      (en & s1_vld & (s1_x < MAX_X)),
      .wr_addr (s1_x[ADDR_WIDTH-1:0]),
      .wr_data (lb0_rd),
      .re      (accept & take & (x_nxt < MAX_X)),
      .rd_addr (x_nxt[ADDR_WIDTH-1:0]),
      .rd_data (lb1_rd)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= WAIT_SOF;
         x_q      <= '0;
         y_q      <= '0;
         s1_vld   <= 1'b0;
         win_val  <= 1'b0;
         win_data <= '0;
         win_sof  <= 1'b0;
         win_eof  <= 1'b0;
         win_sol  <= 1'b0;
         win_eol  <= 1'b0;
      end else if (en) begin
         s1_vld <= accept & take;
         if (accept & take) begin
            x_q     <= x_nxt;
            y_q     <= y_nxt;
            st      <= in_eof ? WAIT_SOF : ACTIVE;
            s1_x    <= x_nxt;
            s1_pix  <= in_data;
            s1_emit <= emit;
            s1_sof  <= (x_nxt == X_TWO) & (y_nxt == 2'd2);
            s1_sol  <= (x_nxt == X_TWO);
            s1_eol  <= in_eol;
            s1_eof  <= in_eof;
         end
         if (s1_vld) begin
            sh1 <= col_new;
            sh2 <= sh1;
         end
         win_val <= s1_vld & s1_emit;
         if (s1_vld & s1_emit) begin
            for (int r = 0; r < WIN_ROWS; r++) begin
               win_data[idx(r, 0)*DATA_WIDTH +: DATA_WIDTH] <= col_new[r];
               win_data[idx(r, 1)*DATA_WIDTH +: DATA_WIDTH] <= sh1[r];
               win_data[idx(r, 2)*DATA_WIDTH +: DATA_WIDTH] <= sh2[r];
            end
            win_sof <= s1_sof;
            win_eof <= s1_eof;
            win_sol <= s1_sol;
            win_eol <= s1_eol;
         end
      end
   end

`ifdef WIN3X3_ERR_EN
   logic                have_first, hf;
   logic [ADDR_WIDTH:0] first_x;

   // A pixel carrying in_sof starts a fresh reference line.
   assign hf = have_first & ~in_sof;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_line_len <= 1'b0;
         have_first   <= 1'b0;
         first_x      <= '0;
      end else if (accept & take) begin
         if (st == WAIT_SOF) err_line_len <= 1'b0;
         if (in_sof) have_first <= 1'b0;
         if (in_eol) begin
            if (x_nxt == MAX_X || (hf && x_nxt != first_x)) err_line_len <= 1'b1;
            if (!hf) begin
               first_x    <= x_nxt;
               have_first <= 1'b1;
            end
         end
      end
   end
`endif

endmodule
